// File: rtl/edge_sync_pkg.sv
// Shared definitions for the edge_sync_array slice: edge modes, parameter limits
// and the deglitch counter width helper.
package edge_sync_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int CHANNELS_MIN    = 1;
    localparam int CHANNELS_MAX    = 32;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILT_CYCLES_MIN = 1;
    localparam int FILT_CYCLES_MAX = 255;

    function automatic int filt_cnt_width(input int filt_cycles);
        return (filt_cycles < 1) ? 1 : $clog2(filt_cycles + 1);
    endfunction

endpackage

// File: rtl/edge_sync_chan.sv
// One channel: synchronizer chain, optional deglitch filter (EDGE_SYNC_FILTER_EN),
// selectable edge detect, one-cycle pulse and sticky status bit.
module edge_sync_chan #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 3
) (
    input  logic       clk2,
    input  logic       reset_n,
    input  logic       data_in,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       level_out,
    output logic       pulse_out,
    output logic       status
);
    import edge_sync_pkg::*;

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("edge_sync_chan: SYNC_STAGES out of range");
    end
    if (FILT_CYCLES < FILT_CYCLES_MIN || FILT_CYCLES > FILT_CYCLES_MAX) begin : g_bad_filt
        $error("edge_sync_chan: FILT_CYCLES out of range");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_level;
    logic                   level;
    logic                   prev_q;
    logic                   pulse_q;
    logic                   status_q;
    logic                   rise;
    logic                   fall;
    logic                   match;
    edge_mode_e             mode_e;

    always_ff @(posedge clk2 or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
        end
    end

    assign sync_level = sync_q[SYNC_STAGES-1];

`ifdef EDGE_SYNC_FILTER_EN
    localparam int CNT_W = filt_cnt_width(FILT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

    logic [CNT_W-1:0] filt_cnt;
    logic             level_q;

    // A new level is accepted only after FILT_CYCLES consecutive mismatching cycles.
    always_ff @(posedge clk2 or negedge reset_n) begin
        if (!reset_n) begin
            filt_cnt <= '0;
            level_q  <= 1'b0;
        end else if (sync_level != level_q) begin
            if (filt_cnt == CNT_LAST) begin
                level_q  <= sync_level;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    assign level = level_q;
`else
    assign level = sync_level;
`endif

    assign mode_e = edge_mode_e'(mode);
    assign rise   = level & ~prev_q;
    assign fall   = ~level & prev_q;

    always_comb begin
        match = 1'b0;
        case (mode_e)
            EDGE_RISE: match = rise;
            EDGE_FALL: match = fall;
            EDGE_BOTH: match = rise | fall;
            default:   match = 1'b0;
        endcase
    end

    // prev tracks level every cycle so that a mode change alone never looks like an edge.
    always_ff @(posedge clk2 or negedge reset_n) begin
        if (!reset_n) begin
            prev_q   <= 1'b0;
            pulse_q  <= 1'b0;
            status_q <= 1'b0;
        end else begin
            prev_q   <= level;
            pulse_q  <= match;
            status_q <= pulse_q | (status_q & ~clr);
        end
    end

    assign level_out = level;
    assign pulse_out = pulse_q;
    assign status    = status_q;

endmodule

// File: rtl/edge_sync_array.sv
// Multi-channel synchronizer and edge detector with maskable interrupt.
// Optional deglitch filter compiled in with EDGE_SYNC_FILTER_EN.
module edge_sync_array #(
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 3
) (
    input  logic                  clk2,
    input  logic                  reset_n,
    input  logic [CHANNELS-1:0]   data_in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clr,
    input  logic [CHANNELS-1:0]   irq_en,
    output logic [CHANNELS-1:0]   level_out,
    output logic [CHANNELS-1:0]   pulse_out,
    output logic [CHANNELS-1:0]   status,
    output logic                  irq
);
    import edge_sync_pkg::*;

    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
        $error("edge_sync_array: CHANNELS out of range");
    end

    logic irq_q;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        edge_sync_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES)
        ) u_chan (
            .clk2      (clk2),
            .reset_n   (reset_n),
            .data_in   (data_in[ch]),
            .mode      (mode[2*ch +: 2]),
            .clr       (clr[ch]),
            .level_out (level_out[ch]),
            .pulse_out (pulse_out[ch]),
            .status    (status[ch])
        );
    end

    always_ff @(posedge clk2 or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(status & irq_en);
        end
    end

    assign irq = irq_q;

endmodule

// File: doc/edge_sync_array.md
# edge_sync_array

Multi-channel asynchronous-input synchronizer and edge detector for the destination clock domain. Each channel passes an asynchronous level through a parametrised flop chain, optionally deglitches it, detects a per-channel selectable edge, emits a one-cycle pulse, and latches a sticky status bit that feeds a maskable interrupt. It replaces the single-channel, rising-only, fixed two-stage edge detector in the synchronizer library.

## Interface
- CHANNELS, 8: number of independent input channels (1..32)
- SYNC_STAGES, 2: synchronizer flops per channel (2..4)
- FILT_CYCLES, 3: consecutive stable cycles a new level needs before it is accepted (1..255); used only with the filter compiled in
- clk2  input  1  destination clock
- reset_n  input  1  asynchronous active-low reset
- data_in  input  CHANNELS  asynchronous levels, one per channel
- mode  input  2*CHANNELS  per-channel edge select, quasi-static, synchronous to clk2: 00 off, 01 rise, 10 fall, 11 both
- clr  input  CHANNELS  write-1-to-clear pulses for status
- irq_en  input  CHANNELS  interrupt mask; 1 = enabled
- level_out  output  CHANNELS  synchronized (filtered) level
- pulse_out  output  CHANNELS  one-cycle edge pulse per channel
- status  output  CHANNELS  sticky event flags
- irq  output  1  registered OR of status & irq_en

## Operation
- Reset: all sync flops, level_out, previous level, filter counters, pulse_out, status, irq = 0.
- Sync chain: sync[0] <= data_in[ch]; sync[i] <= sync[i-1]; s = sync[SYNC_STAGES-1].
- Level: without filter, level_out = s. With filter, level_out is a register; per-channel counter width $clog2(FILT_CYCLES+1); s != level_out increments counter; when counter == FILT_CYCLES-1 and mismatch persists, level_out <= s, counter <= 0; s == level_out clears counter.
- prev <= level_out every cycle, regardless of mode.
- Detect: rise = level_out & ~prev; fall = ~level_out & prev; match per mode; pulse_out <= match (registered).
- Mode 00 never pulses. Mode changes take effect the next cycle; no pulse is generated by a mode change alone because prev tracks continuously.
- status[ch]: set when pulse_out[ch] = 1; cleared by clr[ch]; set and clear in the same cycle leaves status = 1 (set wins).
- irq <= |(status & irq_en).
- A channel held high through reset release produces one rising event after the sync latency; this is intended and software clears it.
- Input pulses shorter than one clk2 period may be missed; shorter than FILT_CYCLES cycles after sync are always rejected with the filter compiled in.

## Timing
- Let edge k be the first clk2 edge that samples a new input level into sync[0].
- No filter: s and level_out change at edge k+SYNC_STAGES-1; pulse_out high for exactly one cycle after edge k+SYNC_STAGES.
- Filter: level_out changes at edge k+SYNC_STAGES-1+FILT_CYCLES; pulse_out one cycle after edge k+SYNC_STAGES+FILT_CYCLES.
- status sets at the edge after pulse_out asserts; irq follows one edge later.
- Reset assertion mid-operation clears all state immediately; no pulse on deassertion beyond the high-input case above.
- Back-to-back edges separated by ≥1 cycle of stable level_out each produce their own pulse.

## Configuration
- EDGE_SYNC_FILTER_EN defined: per-channel deglitch counter and registered level_out as above; FILT_CYCLES active.
- Undefined: no counters; level_out = s; FILT_CYCLES ignored; latency reduced by FILT_CYCLES.

## Structure
- Package edge_sync_pkg: edge-mode enum (EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH), parameter range limits, counter-width function.
- Sub-module edge_sync_chan: one channel's sync chain, filter, edge detect, pulse and status bit; top instantiates CHANNELS copies via generate and forms irq.

## Test plan
- CHANNELS=4, SYNC_STAGES=2, no filter, mode ch0=01: data_in[0] 0->1 sampled at edge 10 -> pulse_out[0] high only in the cycle after edge 12, status[0]=1 after edge 13, irq=1 after edge 14 with irq_en[0]=1.
- Mode ch1=11: drive 0->1->0 with 20-cycle spacing -> exactly two one-cycle pulses on pulse_out[1]; mode 10 on ch2 with the same stimulus -> only the falling pulse.
- Filter on, FILT_CYCLES=3: 2-cycle glitch on data_in[0] -> no level_out or pulse change; 5-cycle high -> level_out rises at edge k+4, pulse one cycle later.
- clr[0] asserted in the same cycle a new pulse_out[0] sets status -> status[0] stays 1; clr alone the next cycle -> status[0]=0, irq drops one edge later.
- reset_n low mid-pulse with data_in=all 1s -> all outputs 0 immediately; after release, each enabled rise channel pulses once at SYNC_STAGES+1 edges.
- mode switched 00->01 while level_out is steady high -> no pulse.
